// File: rtl/led_counter_bank.sv
// led_counter_bank: prescaled bank of up/down/bounce/hold counters driving LED slices
module led_counter_bank #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int LED_W   = 4,
    parameter int TAP_LSB = 22,
    parameter int PRE_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [PRE_W-1:0]        prescale,
    input  logic [2*NUM_CH-1:0]     mode,
    input  logic [NUM_CH-1:0]       load,
    input  logic [CNT_W-1:0]        load_val,
    output logic [NUM_CH*LED_W-1:0] io_led,
    output logic [NUM_CH-1:0]       wrap
);
    localparam logic [CNT_W-1:0] cnt_max = {CNT_W{1'b1}};
    logic [PRE_W-1:0] pcnt;
    logic             tick;
    // >= rather than == so lowering prescale below pcnt still yields a tick
    assign tick = en && (pcnt >= prescale);
    // shared prescaler, frozen while en is low
    always_ff @(posedge clk) begin
        if (rst) pcnt <= '0;
        else if (en) pcnt <= tick ? '0 : pcnt + PRE_W'(1);
    end
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt, nxt;
        logic             dir, nxt_dir, nxt_wrap;
        logic [1:0]       m;
        assign m = mode[2*i +: 2];
        // value, direction and wrap flag this channel would take on a tick
        always_comb begin
            nxt      = cnt;
            nxt_dir  = dir;
            nxt_wrap = 1'b0;
            case (m)
                2'b00: begin
                    nxt      = cnt + CNT_W'(1);
                    nxt_wrap = cnt == cnt_max;
                end
                2'b01: begin
                    nxt      = cnt - CNT_W'(1);
                    nxt_wrap = cnt == '0;
                end
                2'b10: begin
                    if (!dir) begin
                        nxt_wrap = cnt == cnt_max;
                        nxt      = nxt_wrap ? cnt_max - CNT_W'(1) : cnt + CNT_W'(1);
                        nxt_dir  = nxt_wrap;
                    end else begin
                        nxt_wrap = cnt == '0;
                        nxt      = nxt_wrap ? CNT_W'(1) : cnt - CNT_W'(1);
                        nxt_dir  = !nxt_wrap;
                    end
                end
                default: ;
            endcase
        end
        // load beats tick; a tick lost to load is not replayed
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt     <= '0;
                dir     <= 1'b0;
                wrap[i] <= 1'b0;
            end else if (load[i]) begin
                cnt     <= load_val;
                dir     <= 1'b0;
                wrap[i] <= 1'b0;
            end else if (tick) begin
                cnt     <= nxt;
                dir     <= nxt_dir;
                wrap[i] <= nxt_wrap;
            end else begin
                wrap[i] <= 1'b0;
            end
        end
        assign io_led[LED_W*i +: LED_W] = cnt[TAP_LSB +: LED_W];
    end
endmodule

// File: tb/tb_led_counter_bank.sv
// tb_led_counter_bank: directed vector table plus corner sequences for led_counter_bank
module tb_led_counter_bank;
    logic       clk = 1'b0;
    logic       rst, en;
    logic [3:0] prescale, mode, load_val;
    logic [1:0] load;
    logic [3:0] io_led;
    logic [1:0] wrap;
    int         n_chk = 0;
    int         n_fail = 0;

    typedef struct {
        logic       r, e;
        logic [3:0] p, m, lv;
        logic [1:0] l;
        logic [3:0] c0, c1;
        logic [1:0] w;
    } vec_t;
    vec_t tbl[$];

    led_counter_bank #(.NUM_CH(2), .CNT_W(4), .LED_W(2), .TAP_LSB(2), .PRE_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .prescale(prescale), .mode(mode),
        .load(load), .load_val(load_val), .io_led(io_led), .wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic void add(int r, int e, int p, int m, int l, int lv, int c0, int c1, int w);
        vec_t v;
        v.r = 1'(r); v.e = 1'(e); v.p = 4'(p); v.m = 4'(m); v.l = 2'(l); v.lv = 4'(lv);
        v.c0 = 4'(c0); v.c1 = 4'(c1); v.w = 2'(w);
        tbl.push_back(v);
    endfunction

    task automatic check(input int idx, input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec %0d %s: got %0h expected %0h", idx, name, act, exp);
        end
    endtask

    initial begin
        // reset with load asserted: reset wins
        add(1, 1, 0, 0, 3, 9, 0, 0, 0);
        add(1, 1, 0, 0, 3, 9, 0, 0, 0);
        // up count, tick every cycle, wrap at 15->0
        for (int k = 1; k <= 17; k++) add(0, 1, 0, 0, 0, 0, k % 16, k % 16, (k == 16) ? 3 : 0);
        // prescale 3: load 3 (pcnt 0->1), then step every 4 cycles
        add(0, 1, 3, 0, 3, 3, 3, 3, 0);
        add(0, 1, 3, 0, 0, 0, 3, 3, 0);
        add(0, 1, 3, 0, 0, 0, 3, 3, 0);
        add(0, 1, 3, 0, 0, 0, 4, 4, 0);
        for (int k = 0; k < 3; k++) add(0, 1, 3, 0, 0, 0, 4, 4, 0);
        add(0, 1, 3, 0, 0, 0, 5, 5, 0);
        for (int k = 0; k < 3; k++) add(0, 1, 3, 0, 0, 0, 5, 5, 0);
        // en low with pcnt==prescale: nothing may move
        for (int k = 0; k < 5; k++) add(0, 0, 3, 0, 0, 0, 5, 5, 0);
        add(0, 1, 3, 0, 0, 0, 6, 6, 0);
        add(0, 1, 3, 0, 0, 0, 6, 6, 0);
        // down on ch1, hold on ch0
        add(0, 1, 0, 4'b0111, 3, 0, 0, 0, 0);
        add(0, 1, 0, 4'b0111, 0, 0, 0, 15, 2);
        add(0, 1, 0, 4'b0111, 0, 0, 0, 14, 0);
        add(0, 1, 0, 4'b0111, 0, 0, 0, 13, 0);
        add(0, 1, 0, 4'b0111, 2, 0, 0, 0, 0);
        add(0, 1, 0, 4'b0111, 0, 0, 0, 15, 2);
        add(0, 0, 0, 4'b0111, 0, 0, 0, 15, 0);
        add(0, 0, 0, 4'b0111, 0, 0, 0, 15, 0);
        // bounce on ch0 from 14, ch1 holds at 15
        add(0, 1, 0, 4'b1110, 1, 14, 14, 15, 0);
        add(0, 1, 0, 4'b1110, 0, 0, 15, 15, 0);
        add(0, 1, 0, 4'b1110, 0, 0, 14, 15, 1);
        for (int k = 13; k >= 0; k--) add(0, 1, 0, 4'b1110, 0, 0, k, 15, 0);
        add(0, 1, 0, 4'b1110, 0, 0, 1, 15, 1);
        add(0, 1, 0, 4'b1110, 0, 0, 2, 15, 0);
        // load on ch0 during a tick; ch1 still steps and wraps
        add(0, 1, 0, 0, 1, 7, 7, 0, 2);
        add(0, 1, 0, 0, 0, 0, 8, 1, 0);
        // reset together with load, then prescale lowered 9->2 at pcnt 6
        add(1, 1, 9, 0, 3, 5, 0, 0, 0);
        for (int k = 0; k < 6; k++) add(0, 1, 9, 0, 0, 0, 0, 0, 0);
        add(0, 1, 2, 0, 0, 0, 1, 1, 0);
        add(0, 1, 2, 0, 0, 0, 1, 1, 0);
        add(0, 1, 2, 0, 0, 0, 1, 1, 0);
        add(0, 1, 2, 0, 0, 0, 2, 2, 0);
        add(0, 1, 2, 0, 0, 0, 2, 2, 0);
        add(0, 1, 2, 0, 0, 0, 2, 2, 0);
        add(0, 1, 2, 0, 0, 0, 3, 3, 0);

        foreach (tbl[i]) begin
            rst = tbl[i].r; en = tbl[i].e; prescale = tbl[i].p; mode = tbl[i].m;
            load = tbl[i].l; load_val = tbl[i].lv;
            @(posedge clk);
            #1;
            check(i, "cnt0", 8'(dut.g_ch[0].cnt), 8'(tbl[i].c0));
            check(i, "cnt1", 8'(dut.g_ch[1].cnt), 8'(tbl[i].c1));
            check(i, "io_led", 8'(io_led), 8'({tbl[i].c1[3:2], tbl[i].c0[3:2]}));
            check(i, "wrap", 8'(wrap), 8'(tbl[i].w));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
